// File: rtl/sspm_ocp_connector.sv
`default_nettype none
// ============================================================================
// Module   : sspm_ocp_connector
// Brief    : OCP slave bridging one Patmos core to its TDM slot on the shared
//            scratchpad; one access per grant, supervisor-protected top region.
//            Optional grant-wait timeout: define SSPM_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sspm_ocp_connector #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int PROT_WORDS     = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    io_superMode,
    input  logic [2:0]              io_ocp_M_Cmd,
    input  logic [31:0]             io_ocp_M_Addr,
    input  logic [DATA_WIDTH-1:0]   io_ocp_M_Data,
    input  logic [DATA_WIDTH/8-1:0] io_ocp_M_ByteEn,
    output logic [1:0]              io_ocp_S_Resp,
    output logic [DATA_WIDTH-1:0]   io_ocp_S_Data,
    input  logic                    io_connectorSignals_select,
    input  logic [DATA_WIDTH-1:0]   io_connectorSignals_data_in,
    output logic [DATA_WIDTH-1:0]   io_connectorSignals_data_out,
    output logic [ADDR_WIDTH-1:0]   io_connectorSignals_addr,
    output logic                    io_connectorSignals_en,
    output logic [DATA_WIDTH/8-1:0] io_connectorSignals_we
);

    localparam int                  c_be_width  = DATA_WIDTH / 8;
    localparam logic [2:0]          c_cmd_wr    = 3'd1;
    localparam logic [2:0]          c_cmd_rd    = 3'd2;
    localparam logic [1:0]          c_resp_null = 2'd0;
    localparam logic [1:0]          c_resp_dva  = 2'd1;
    localparam logic [1:0]          c_resp_fail = 2'd2;
    localparam logic [1:0]          c_resp_err  = 2'd3;
    // First protected word index; one extra bit so PROT_WORDS = 0 lands past the top.
    localparam logic [ADDR_WIDTH:0] c_prot_base =
        (ADDR_WIDTH+1)'((64'd1 << ADDR_WIDTH) - 64'(PROT_WORDS));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_is_rd;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [c_be_width-1:0]   r_byte_en;
    logic [1:0]              r_resp;

    logic                    w_is_wr;
    logic                    w_is_rd;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic                    w_protected;
    logic                    w_early_dva;
    logic                    w_early_err;
    logic                    w_timeout;
    logic                    w_unused_addr;

    assign w_is_wr       = (io_ocp_M_Cmd == c_cmd_wr);
    assign w_is_rd       = (io_ocp_M_Cmd == c_cmd_rd);
    assign w_accept      = (r_state == S_IDLE) && (w_is_wr || w_is_rd);
    assign w_addr        = io_ocp_M_Addr[ADDR_WIDTH+1:2];
    assign w_unused_addr = ^{io_ocp_M_Addr[31:ADDR_WIDTH+2], io_ocp_M_Addr[1:0]};
    assign w_protected   = (PROT_WORDS != 0) && ({1'b0, w_addr} >= c_prot_base);
    assign w_early_dva   = w_is_wr && (io_ocp_M_ByteEn == '0);
    assign w_early_err   = w_is_wr && w_protected && !io_superMode;

`ifdef SSPM_TIMEOUT_EN
    localparam int                   c_cnt_width = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_width-1:0] c_cnt_last = c_cnt_width'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_width-1:0] r_wait_cnt;

    assign w_timeout = (r_state == S_WAIT) && !io_connectorSignals_select &&
                       (r_wait_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_accept) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_WAIT) && !io_connectorSignals_select) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_early_dva || w_early_err) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (io_connectorSignals_select || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Response code is fixed at accept, except a timeout overrides it to FAIL.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_rd   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_byte_en <= '0;
            r_resp    <= c_resp_null;
        end else if (w_accept) begin
            r_is_rd   <= w_is_rd;
            r_addr    <= w_addr;
            r_data    <= io_ocp_M_Data;
            r_byte_en <= io_ocp_M_ByteEn;
            r_resp    <= (w_early_err && !w_early_dva) ? c_resp_err : c_resp_dva;
        end else if (w_timeout) begin
            r_resp    <= c_resp_fail;
        end
    end

    always_comb begin
        io_connectorSignals_en       = 1'b0;
        io_connectorSignals_addr     = '0;
        io_connectorSignals_data_out = '0;
        io_connectorSignals_we       = '0;
        io_ocp_S_Resp                = c_resp_null;
        io_ocp_S_Data                = '0;
        if (r_state == S_WAIT) begin
            io_connectorSignals_en       = io_connectorSignals_select;
            io_connectorSignals_addr     = r_addr;
            io_connectorSignals_data_out = r_data;
            io_connectorSignals_we       = r_is_rd ? '0 : r_byte_en;
        end
        if (r_state == S_RESP) begin
            io_ocp_S_Resp = r_resp;
            if (r_is_rd && (r_resp == c_resp_dva)) begin
                io_ocp_S_Data = io_connectorSignals_data_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sspm_ocp_connector.sv
`default_nettype none
// ============================================================================
// Module   : tb_sspm_ocp_connector
// Brief    : Directed and randomized checks of sspm_ocp_connector against a
//            transaction-level model with its own scratchpad image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sspm_ocp_connector;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        super_mode = 1'b0;
    logic [2:0]  m_cmd = 3'd0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_be = '0;
    logic [1:0]  s_resp;
    logic [31:0] s_data;
    logic        sel = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [15:0] addr;
    logic        en;
    logic [3:0]  we;

    int n_vec = 0;
    int n_err = 0;

    bit [31:0] ref_mem [0:65535];
    bit [31:0] sspm    [0:65535];

    always #5 clk = ~clk;

    sspm_ocp_connector #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (32),
        .PROT_WORDS    (256),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk                          (clk),
        .reset                        (reset),
        .io_superMode                 (super_mode),
        .io_ocp_M_Cmd                 (m_cmd),
        .io_ocp_M_Addr                (m_addr),
        .io_ocp_M_Data                (m_data),
        .io_ocp_M_ByteEn              (m_be),
        .io_ocp_S_Resp                (s_resp),
        .io_ocp_S_Data                (s_data),
        .io_connectorSignals_select   (sel),
        .io_connectorSignals_data_in  (din),
        .io_connectorSignals_data_out (dout),
        .io_connectorSignals_addr     (addr),
        .io_connectorSignals_en       (en),
        .io_connectorSignals_we       (we)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic sup);
        m_cmd = c; m_addr = a; m_data = d; m_be = be; super_mode = sup;
    endtask

    task automatic junk();
        drive(3'($urandom_range(0, 7)), $urandom(), $urandom(), 4'($urandom()), 1'($urandom()));
    endtask

    task automatic test_reset();
        reset = 1'b1; drive(3'd2, 32'h10, 32'hFFFF_FFFF, 4'hF, 1'b1); sel = 1'b1; din = 32'hCAFE_F00D;
        tick(); tick(); sample();
        n_vec++;
        if ({s_resp, s_data, dout, addr, en, we} !== 87'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got resp=%0d sdata=%h dout=%h addr=%h en=%b we=%b, expected all 0",
                     s_resp, s_data, dout, addr, en, we);
        end
        tick(); reset = 1'b0; drive(3'd0, 0, 0, 0, 0); sel = 1'b0; sample();
        n_vec++;
        if ({s_resp, s_data, en, addr} !== 51'd0) begin
            n_err++;
            $display("FAIL reset_idle: got resp=%0d sdata=%h en=%b addr=%h, expected 0", s_resp, s_data, en, addr);
        end
    endtask

    task automatic test_read_latency();
        tick(); drive(3'd2, 32'h0000_0010, 32'h0, 4'hF, 1'b0); sample();
        tick(); drive(3'd0, 0, 0, 0, 0); sample();
        n_vec++;
        if (en !== 1'b0 || s_resp !== 2'd0) begin
            n_err++; $display("FAIL rd_wait: got en=%b resp=%0d, expected en=0 resp=0", en, s_resp);
        end
        tick(); sample();
        tick(); sel = 1'b1; sample();
        n_vec++;
        if (en !== 1'b1 || addr !== 16'h0004 || we !== 4'h0) begin
            n_err++; $display("FAIL rd_access: got en=%b addr=%h we=%b, expected en=1 addr=0004 we=0000", en, addr, we);
        end
        tick(); sel = 1'b0; din = 32'hDEAD_BEEF; sample();
        n_vec++;
        if (s_resp !== 2'd1 || s_data !== 32'hDEAD_BEEF || en !== 1'b0) begin
            n_err++; $display("FAIL rd_resp: got resp=%0d data=%h en=%b, expected resp=1 data=deadbeef en=0", s_resp, s_data, en);
        end
        tick(); sample();
        n_vec++;
        if (s_resp !== 2'd0 || s_data !== 32'h0) begin
            n_err++; $display("FAIL rd_resp_once: got resp=%0d data=%h, expected resp=0 data=0", s_resp, s_data);
        end
    endtask

    task automatic test_write_bytes();
        tick(); drive(3'd1, 32'h20, 32'h1234_5678, 4'b0101, 1'b0); sample();
        tick(); drive(3'd0, 0, 0, 0, 0); sel = 1'b1; sample();
        n_vec++;
        if (en !== 1'b1 || we !== 4'b0101 || dout !== 32'h1234_5678 || addr !== 16'h0008) begin
            n_err++; $display("FAIL wr_access: got en=%b we=%b dout=%h addr=%h, expected 1 0101 12345678 0008", en, we, dout, addr);
        end
        tick(); sel = 1'b0; din = 32'hFFFF_FFFF; sample();
        n_vec++;
        if (s_resp !== 2'd1 || s_data !== 32'h0) begin
            n_err++; $display("FAIL wr_resp: got resp=%0d data=%h, expected resp=1 data=0", s_resp, s_data);
        end
    endtask

    task automatic test_early();
        logic [15:0] words [4] = '{16'hFFFF, 16'hFF00, 16'hFEFF, 16'hFFFF};
        logic        sups  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            logic [1:0] exp_resp;
            logic       exp_en;
            exp_en   = (words[i] < 16'hFF00) || sups[i];
            exp_resp = exp_en ? 2'd1 : 2'd3;
            tick(); drive(3'd1, {14'h0, words[i], 2'b00}, 32'hA5A5_0000 + i, 4'hF, sups[i]); sel = 1'b0; sample();
            tick(); drive(3'd0, 0, 0, 0, 0); sel = 1'b1; sample();
            n_vec++;
            if (en !== exp_en || (exp_en && addr !== words[i])) begin
                n_err++; $display("FAIL prot_access[%0d]: got en=%b addr=%h, expected en=%b addr=%h", i, en, addr, exp_en, words[i]);
            end
            if (exp_en) begin
                tick(); sel = 1'b0; sample();
            end
            n_vec++;
            if (s_resp !== exp_resp) begin
                n_err++; $display("FAIL prot_resp[%0d]: got resp=%0d, expected %0d", i, s_resp, exp_resp);
            end
            tick(); sel = 1'b0; sample();
        end
        tick(); drive(3'd1, 32'h44, 32'h1, 4'h0, 1'b0); sample();
        tick(); drive(3'd0, 0, 0, 0, 0); sel = 1'b1; sample();
        n_vec++;
        if (s_resp !== 2'd1 || en !== 1'b0) begin
            n_err++; $display("FAIL zero_byteen: got resp=%0d en=%b, expected resp=1 en=0", s_resp, en);
        end
        tick(); sel = 1'b0; sample();
    endtask

    task automatic test_single_outstanding();
        tick(); drive(3'd2, 32'h40, 0, 4'hF, 1'b0); sample();
        tick(); drive(3'd2, 32'h80, 0, 4'hF, 1'b0); sample();
        tick(); sel = 1'b1; sample();
        n_vec++;
        if (en !== 1'b1 || addr !== 16'h0010) begin
            n_err++; $display("FAIL second_cmd_access: got en=%b addr=%h, expected en=1 addr=0010", en, addr);
        end
        tick(); sel = 1'b0; din = 32'h0BAD_CAFE; sample();
        n_vec++;
        if (s_resp !== 2'd1 || s_data !== 32'h0BAD_CAFE) begin
            n_err++; $display("FAIL second_cmd_resp: got resp=%0d data=%h, expected 1 0badcafe", s_resp, s_data);
        end
        tick(); drive(3'd0, 0, 0, 0, 0); sel = 1'b1; sample();
        n_vec++;
        if (s_resp !== 2'd0 || en !== 1'b0) begin
            n_err++; $display("FAIL second_cmd_dropped: got resp=%0d en=%b, expected resp=0 en=0", s_resp, en);
        end
        tick(); sample();
        n_vec++;
        if (s_resp !== 2'd0 || en !== 1'b0) begin
            n_err++; $display("FAIL second_cmd_quiet: got resp=%0d en=%b, expected resp=0 en=0", s_resp, en);
        end
        tick(); sel = 1'b0; sample();
    endtask

    task automatic test_reset_in_wait();
        tick(); drive(3'd2, 32'h30, 32'h55, 4'hF, 1'b0); sample();
        tick(); drive(3'd0, 0, 0, 0, 0); reset = 1'b1; sample();
        tick(); reset = 1'b0; sel = 1'b1; sample();
        n_vec++;
        if ({s_resp, s_data, dout, addr, en, we} !== 87'd0) begin
            n_err++; $display("FAIL reset_wait_outputs: got resp=%0d sdata=%h dout=%h addr=%h en=%b we=%b, expected all 0",
                              s_resp, s_data, dout, addr, en, we);
        end
        tick(); sel = 1'b0; sample();
        n_vec++;
        if (s_resp !== 2'd0) begin
            n_err++; $display("FAIL reset_wait_noresp: got resp=%0d, expected 0", s_resp);
        end
        tick(); drive(3'd2, 32'h30, 0, 4'hF, 1'b0); sample();
        tick(); drive(3'd0, 0, 0, 0, 0); sel = 1'b1; sample();
        n_vec++;
        if (en !== 1'b1 || addr !== 16'h000C) begin
            n_err++; $display("FAIL reset_fresh_access: got en=%b addr=%h, expected en=1 addr=000c", en, addr);
        end
        tick(); sel = 1'b0; din = 32'h1357_9BDF; sample();
        n_vec++;
        if (s_resp !== 2'd1 || s_data !== 32'h1357_9BDF) begin
            n_err++; $display("FAIL reset_fresh_resp: got resp=%0d data=%h, expected 1 13579bdf", s_resp, s_data);
        end
    endtask

    task automatic test_wait_bound();
`ifdef SSPM_TIMEOUT_EN
        tick(); drive(3'd2, 32'h8, 0, 4'hF, 1'b0); sel = 1'b0; sample();
        for (int k = 1; k <= 8; k++) begin
            tick(); drive(3'd0, 0, 0, 0, 0); sample();
            n_vec++;
            if (s_resp !== 2'd0 || en !== 1'b0) begin
                n_err++; $display("FAIL timeout_wait[%0d]: got resp=%0d en=%b, expected 0 0", k, s_resp, en);
            end
        end
        tick(); din = 32'hFFFF_0000; sample();
        n_vec++;
        if (s_resp !== 2'd2 || s_data !== 32'h0 || en !== 1'b0) begin
            n_err++; $display("FAIL timeout_fail: got resp=%0d data=%h en=%b, expected 2 0 0", s_resp, s_data, en);
        end
        tick(); drive(3'd2, 32'h8, 0, 4'hF, 1'b0); sample();
        for (int k = 1; k <= 7; k++) begin
            tick(); drive(3'd0, 0, 0, 0, 0); sample();
        end
        tick(); sel = 1'b1; sample();
        n_vec++;
        if (en !== 1'b1) begin
            n_err++; $display("FAIL timeout_select_wins: got en=%b, expected 1", en);
        end
        tick(); sel = 1'b0; sample();
        n_vec++;
        if (s_resp !== 2'd1) begin
            n_err++; $display("FAIL timeout_select_resp: got resp=%0d, expected 1", s_resp);
        end
`else
        tick(); drive(3'd2, 32'h8, 0, 4'hF, 1'b0); sel = 1'b0; sample();
        for (int k = 1; k <= 30; k++) begin
            tick(); drive(3'd0, 0, 0, 0, 0); sample();
            n_vec++;
            if (s_resp !== 2'd0 || en !== 1'b0) begin
                n_err++; $display("FAIL long_wait[%0d]: got resp=%0d en=%b, expected 0 0", k, s_resp, en);
            end
        end
        tick(); sel = 1'b1; sample();
        n_vec++;
        if (en !== 1'b1 || addr !== 16'h0002) begin
            n_err++; $display("FAIL long_wait_access: got en=%b addr=%h, expected 1 0002", en, addr);
        end
        tick(); sel = 1'b0; sample();
        n_vec++;
        if (s_resp !== 2'd1) begin
            n_err++; $display("FAIL long_wait_resp: got resp=%0d, expected 1", s_resp);
        end
`endif
        tick(); sel = 1'b0; sample();
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  c;
            logic [15:0] w;
            logic [31:0] a, d, exp_rd, rd;
            logic [3:0]  be, exp_we;
            logic        sup, early;
            logic [1:0]  exp_early;
            int          dly;
            c   = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd2;
            w   = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 15))
                                              : 16'(16'hFFF0 + $urandom_range(0, 15));
            a   = $urandom();
            a[17:2] = w;
            d   = $urandom();
            be  = 4'($urandom());
            sup = 1'($urandom());
            dly = $urandom_range(0, 5);
            early = 1'b0; exp_early = 2'd1;
            if (c == 3'd1 && be == 4'h0) begin
                early = 1'b1;
            end else if (c == 3'd1 && w >= 16'hFF00 && !sup) begin
                early = 1'b1; exp_early = 2'd3;
            end
            exp_rd = ref_mem[w];
            exp_we = (c == 3'd1) ? be : 4'h0;
            if (c == 3'd1 && !early) begin
                for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
            end

            tick(); drive(c, a, d, be, sup); sel = 1'($urandom()); sample();
            n_vec++;
            if (s_resp !== 2'd0 || en !== 1'b0) begin
                n_err++; $display("FAIL rnd_accept[%0d]: got resp=%0d en=%b, expected 0 0", n, s_resp, en);
            end
            if (early) begin
                tick(); junk(); sel = 1'($urandom()); sample();
                n_vec++;
                if (s_resp !== exp_early || en !== 1'b0 || s_data !== 32'h0) begin
                    n_err++; $display("FAIL rnd_early[%0d]: got resp=%0d en=%b data=%h, expected %0d 0 0",
                                      n, s_resp, en, s_data, exp_early);
                end
            end else begin
                for (int k = 0; k < dly; k++) begin
                    tick(); junk(); sel = 1'b0; sample();
                    n_vec++;
                    if (en !== 1'b0 || s_resp !== 2'd0) begin
                        n_err++; $display("FAIL rnd_wait[%0d]: got en=%b resp=%0d, expected 0 0", n, en, s_resp);
                    end
                end
                tick(); junk(); sel = 1'b1; sample();
                n_vec++;
                if (en !== 1'b1 || addr !== w || we !== exp_we || dout !== d) begin
                    n_err++; $display("FAIL rnd_access[%0d]: got en=%b addr=%h we=%b dout=%h, expected 1 %h %b %h",
                                      n, en, addr, we, dout, w, exp_we, d);
                end
                if (en === 1'b1) begin
                    for (int b = 0; b < 4; b++) if (we[b] === 1'b1) sspm[addr][8*b +: 8] = dout[8*b +: 8];
                end
                rd = sspm[addr];
                tick(); junk(); sel = 1'($urandom()); din = (c == 3'd2) ? rd : $urandom(); sample();
                n_vec++;
                if (s_resp !== 2'd1 || s_data !== ((c == 3'd2) ? exp_rd : 32'h0)) begin
                    n_err++; $display("FAIL rnd_resp[%0d]: got resp=%0d data=%h, expected 1 %h",
                                      n, s_resp, s_data, (c == 3'd2) ? exp_rd : 32'h0);
                end
            end
            tick(); drive(3'd0, 0, 0, 0, 0); sel = 1'($urandom()); sample();
            n_vec++;
            if (s_resp !== 2'd0 || en !== 1'b0) begin
                n_err++; $display("FAIL rnd_idle[%0d]: got resp=%0d en=%b, expected 0 0", n, s_resp, en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_bytes();
        test_early();
        test_single_outstanding();
        test_reset_in_wait();
        test_wait_bound();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
